// File: rtl/bitwise_pkg.sv
// rtl/bitwise_pkg.sv - shared encodings for the slice-serial bitwise ALU
//
// Purpose : operation and FSM state encodings, plus the slice-index width
//           helper used by bitwise_alu_seq.
// Ports   : none (package).

package bitwise_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width is ceil(log2(n)) + 1, which is never below 1 (n == 1 gives 1).
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bitwise_slice.sv
// rtl/bitwise_slice.sv - combinational bitwise operation on one slice
//
// Purpose : applies the selected bitwise operation to one SLICE-bit slice.
// Ports   : a, b [SLICE-1:0] in  - operand slices
//           op   [2:0]       in  - operation select (op_e encoding)
//           y    [SLICE-1:0] out - result slice

module bitwise_slice
  import bitwise_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/bitwise_alu_seq.sv
// rtl/bitwise_alu_seq.sv - slice-serial bitwise ALU with valid/ready handshake
//
// Purpose : latches two WIDTH-bit operands and an op, then computes the result
//           SLICE bits per cycle over N = WIDTH/SLICE cycles, presenting it
//           with zero / all-ones flags until the consumer takes it.
// Ports   : clock            in  - rising-edge clock
//           reset            in  - asynchronous active-low reset
//           in_valid         in  - request valid
//           in_ready         out - request accepted this cycle
//           in1, in2 [W-1:0] in  - operands
//           op [2:0]         in  - operation select
//           out_valid        out - result valid (DONE state)
//           out_ready        in  - consumer accepts result
//           out [W-1:0]      out - result register
//           out_zero         out - result == 0
//           out_ones         out - result == all ones
//           busy             out - computing (BUSY state)

module bitwise_alu_seq
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones,
  output logic             busy
);

  // Guarded so a bad SLICE reports through the check below rather than
  // failing on a division by zero first.
  localparam int N     = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int IDX_W = idx_width(N);

  generate
    if (SLICE < 1) begin : g_bad_slice
      $error("bitwise_alu_seq: SLICE must be at least 1");
    end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("bitwise_alu_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_e             state;
  state_e             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_nxt;
  logic [SLICE-1:0]   a_sl;
  logic [SLICE-1:0]   b_sl;
  logic [SLICE-1:0]   y_sl;
  logic               accept;
  logic               last_slice;

  assign accept     = in_valid & in_ready;
  assign last_slice = (idx == IDX_W'(N - 1));
  assign out_valid  = (state == ST_DONE);
  assign busy       = (state == ST_BUSY);
  assign out        = result;

  // Select the operand slice addressed by the current index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
  end

  bitwise_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  // Result as it will look after this edge's slice is written; the flags on
  // the final edge are taken from this full-width value.
  always_comb begin
    result_nxt = result;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        result_nxt[k*SLICE +: SLICE] = y_sl;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_slice) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Taking a new request while handing off the result avoids an idle bubble.
        in_ready = out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? ST_BUSY : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result   <= '0;
      out_zero <= 1'b1;
      out_ones <= 1'b0;
    end else if (accept) begin
      a_q    <= in1;
      b_q    <= in2;
      op_q   <= op;
      idx    <= '0;
      // Clear so no slice of the previous result survives into this one.
      result <= '0;
    end else if (state == ST_BUSY) begin
      result <= result_nxt;
      if (last_slice) begin
        // Wrap to 0 rather than counting to N so the index stays in range.
        idx      <= '0;
        out_zero <= (result_nxt == '0);
        out_ones <= (&result_nxt);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
